// File: rtl/acc_win_multi.sv
// acc_win_multi: per-channel windowed accumulator.
//   Samples arrive on a valid/ready stream tagged with a channel number.
//   Each channel sums WIN samples. When a window completes, the tagged
//   sum and its overflow flag are loaded into a one-deep output register,
//   which has its own valid/ready handshake.
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   in_val/in_rdy/in_ch/in_data     input sample stream
//   clr                             synchronous clear of all accumulators
//   out_val/out_rdy/out_ch/out_sum/out_ovf   window result stream
// Build option:
//   ACC_WIN_SAT_EN  when defined, the accumulator saturates at all-ones
//                   instead of wrapping.
module acc_win_multi #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SUM_W  = 16,
  parameter int unsigned CH     = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned WIN    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clr,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [CH_W-1:0]   out_ch,
  output logic [SUM_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int unsigned CNT_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

  logic [SUM_W-1:0] acc_q [CH];
  logic [SUM_W-1:0] acc_d [CH];
  logic [CNT_W-1:0] cnt_q [CH];
  logic [CNT_W-1:0] cnt_d [CH];
  logic [CH-1:0]    ovf_q, ovf_d;

  logic             out_val_q, out_val_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;

  logic             xfer;
  logic [SUM_W:0]   sum_ext;
  logic [SUM_W-1:0] sum_nxt;
  logic             ovf_nxt;

  assign in_rdy = !rst && !clr && (!out_val_q || out_rdy);
  assign xfer   = in_val && in_rdy;

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_val_d = out_val_q;
    out_ch_d  = out_ch_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;
    sum_ext   = '0;
    sum_nxt   = '0;
    ovf_nxt   = 1'b0;

    if (out_val_q && out_rdy) begin
      out_val_d = 1'b0;
    end

    // Tags outside 0..CH-1 match no channel, so they are accepted and dropped.
    for (int unsigned c = 0; c < CH; c++) begin
      if (xfer && (32'(in_ch) == c)) begin
        sum_ext = {1'b0, acc_q[c]} + (SUM_W + 1)'(in_data);
`ifdef ACC_WIN_SAT_EN
        sum_nxt = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
`else
        sum_nxt = sum_ext[SUM_W-1:0];
`endif
        ovf_nxt = ovf_q[c] | sum_ext[SUM_W];
        if (cnt_q[c] == CNT_LAST) begin
          acc_d[c]  = '0;
          cnt_d[c]  = '0;
          ovf_d[c]  = 1'b0;
          // Loading here also covers a handshake on the same edge: no bubble.
          out_val_d = 1'b1;
          out_ch_d  = in_ch;
          out_sum_d = sum_nxt;
          out_ovf_d = ovf_nxt;
        end else begin
          acc_d[c] = sum_nxt;
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
          ovf_d[c] = ovf_nxt;
        end
      end
    end

    // clr holds in_rdy low, so no transfer competes with it; output untouched.
    if (clr) begin
      for (int unsigned c = 0; c < CH; c++) begin
        acc_d[c] = '0;
        cnt_d[c] = '0;
      end
      ovf_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '{default: '0};
      cnt_q     <= '{default: '0};
      ovf_q     <= '0;
      out_val_q <= 1'b0;
      out_ch_q  <= '0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_val_q <= out_val_d;
      out_ch_q  <= out_ch_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_val = out_val_q;
  assign out_ch  = out_ch_q;
  assign out_sum = out_sum_q;
  assign out_ovf = out_ovf_q;

endmodule

// File: tb/tb_acc_win_multi.sv
// Directed testbench for acc_win_multi.
//   dut   : CH=4 with a 3-bit tag so out-of-range tags (e.g. 5) can be driven.
//   dut8  : same, with SUM_W=8 for the overflow/saturation case.
// Both instances share all inputs.
module tb_acc_win_multi;

  logic       clk = 1'b0;
  logic       rst, in_val, clr, out_rdy;
  logic [2:0] in_ch;
  logic [7:0] in_data;

  logic        in_rdy, out_val, out_ovf;
  logic [2:0]  out_ch;
  logic [15:0] out_sum;

  logic        in_rdy8, out_val8, out_ovf8;
  logic [2:0]  out_ch8;
  logic [7:0]  out_sum8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  acc_win_multi #(.DATA_W(8), .SUM_W(16), .CH(4), .CH_W(3), .WIN(4)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy), .in_ch(in_ch),
    .in_data(in_data), .clr(clr), .out_val(out_val), .out_rdy(out_rdy),
    .out_ch(out_ch), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  acc_win_multi #(.DATA_W(8), .SUM_W(8), .CH(4), .CH_W(3), .WIN(4)) dut8 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy8), .in_ch(in_ch),
    .in_data(in_data), .clr(clr), .out_val(out_val8), .out_rdy(out_rdy),
    .out_ch(out_ch8), .out_sum(out_sum8), .out_ovf(out_ovf8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_val = 1'b0; step(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_val = 1'b0; in_ch = '0; in_data = '0; out_rdy = 1'b1;
    step();
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy got=%0b exp=0", in_rdy); end
    step();
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy2 got=%0b exp=0", in_rdy); end
    checks++;
    if (out_val !== 1'b0 || out_sum !== 16'd0 || out_ch !== 3'd0 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got val=%0b sum=%0d ch=%0d ovf=%0b exp all 0", out_val, out_sum, out_ch, out_ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1; in_ch = 3'd0; in_data = 8'(i + 1);
      step();
      if (i < 3) begin
        checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL single_early_val i=%0d got=%0b exp=0", i, out_val); end
      end
    end
    in_val = 1'b0;
    checks++;
    if (out_val !== 1'b1 || out_ch !== 3'd0 || out_sum !== 16'd10 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL single_result got val=%0b ch=%0d sum=%0d ovf=%0b exp 1/0/10/0", out_val, out_ch, out_sum, out_ovf);
    end
    step();
    checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL single_val_drop got=%0b exp=0", out_val); end
  endtask

  task automatic test_interleave();
    logic [2:0]  chs  [8] = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2};
    logic [7:0]  dats [8] = '{8'd10, 8'd5, 8'd20, 8'd5, 8'd30, 8'd5, 8'd40, 8'd5};
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_val = 1'b1; in_ch = chs[i]; in_data = dats[i];
      step();
      if (i == 6) begin
        checks++;
        if (out_val !== 1'b1 || out_ch !== 3'd1 || out_sum !== 16'd100) begin
          failures++; $display("FAIL interleave_ch1 got val=%0b ch=%0d sum=%0d exp 1/1/100", out_val, out_ch, out_sum);
        end
      end else if (i == 7) begin
        checks++;
        if (out_val !== 1'b1 || out_ch !== 3'd2 || out_sum !== 16'd20) begin
          failures++; $display("FAIL interleave_ch2 got val=%0b ch=%0d sum=%0d exp 1/2/20", out_val, out_ch, out_sum);
        end
      end else begin
        checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL interleave_idle i=%0d got=%0b exp=0", i, out_val); end
      end
    end
    in_val = 1'b0;
    step();
    checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL interleave_once got=%0b exp=0", out_val); end
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1; in_ch = 3'd0; in_data = 8'(i + 1);
      step();
    end
    in_val = 1'b1; in_ch = 3'd3; in_data = 8'd9;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_val !== 1'b1 || out_sum !== 16'd10 || out_ch !== 3'd0 || in_rdy !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold k=%0d got val=%0b sum=%0d ch=%0d rdy=%0b exp 1/10/0/0", k, out_val, out_sum, out_ch, in_rdy);
      end
      step();
    end
    out_rdy = 1'b1;
    #1;
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL bp_release_rdy got=%0b exp=1", in_rdy); end
    step();
    checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL bp_handshake got=%0b exp=0", out_val); end
    // The held ch3 sample (9) went in on the handshake edge; three more 1s close it.
    for (int i = 0; i < 3; i++) begin
      in_val = 1'b1; in_ch = 3'd3; in_data = 8'd1;
      step();
    end
    in_val = 1'b0;
    checks++;
    if (out_val !== 1'b1 || out_ch !== 3'd3 || out_sum !== 16'd12) begin
      failures++; $display("FAIL bp_ch3_result got val=%0b ch=%0d sum=%0d exp 1/3/12", out_val, out_ch, out_sum);
    end
    step();
  endtask

  task automatic test_overflow();
    do_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1; in_ch = 3'd0; in_data = 8'd100;
      step();
    end
    in_val = 1'b0;
    checks++;
    if (out_val !== 1'b1 || out_sum !== 16'd400 || out_ovf !== 1'b0) begin
      failures++; $display("FAIL ovf_wide got val=%0b sum=%0d ovf=%0b exp 1/400/0", out_val, out_sum, out_ovf);
    end
    checks++;
`ifdef ACC_WIN_SAT_EN
    if (out_val8 !== 1'b1 || out_sum8 !== 8'd255 || out_ovf8 !== 1'b1) begin
      failures++; $display("FAIL ovf_sat got val=%0b sum=%0d ovf=%0b exp 1/255/1", out_val8, out_sum8, out_ovf8);
    end
`else
    if (out_val8 !== 1'b1 || out_sum8 !== 8'd144 || out_ovf8 !== 1'b1) begin
      failures++; $display("FAIL ovf_wrap got val=%0b sum=%0d ovf=%0b exp 1/144/1", out_val8, out_sum8, out_ovf8);
    end
`endif
    step();
    checks++; if (out_val8 !== 1'b0) begin failures++; $display("FAIL ovf_drop got=%0b exp=0", out_val8); end
  endtask

  task automatic test_clr_and_range();
    out_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_val = 1'b1; in_ch = 3'd0; in_data = 8'd7;
      step();
    end
    in_val = 1'b0; clr = 1'b1;
    #1;
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL clr_in_rdy got=%0b exp=0", in_rdy); end
    step();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_val = 1'b1; in_ch = 3'd5; in_data = 8'd50;
      #1;
      checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL range_accept i=%0d got=%0b exp=1", i, in_rdy); end
      step();
      checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL range_no_out i=%0d got=%0b exp=0", i, out_val); end
    end
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1; in_ch = 3'd0; in_data = 8'd1;
      step();
    end
    in_val = 1'b0;
    checks++;
    if (out_val !== 1'b1 || out_ch !== 3'd0 || out_sum !== 16'd4 || out_ovf !== 1'b0) begin
      failures++; $display("FAIL clr_result got val=%0b ch=%0d sum=%0d ovf=%0b exp 1/0/4/0", out_val, out_ch, out_sum, out_ovf);
    end
    step();
    // Pending result survives clr and still hands off during clr.
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1; in_ch = 3'd1; in_data = 8'd2;
      step();
    end
    in_val = 1'b0; clr = 1'b1;
    step();
    checks++;
    if (out_val !== 1'b1 || out_sum !== 16'd8 || out_ch !== 3'd1) begin
      failures++; $display("FAIL clr_pending got val=%0b sum=%0d ch=%0d exp 1/8/1", out_val, out_sum, out_ch);
    end
    out_rdy = 1'b1;
    step();
    checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL clr_handshake got=%0b exp=0", out_val); end
    clr = 1'b0;
  endtask

  task automatic test_rst_pending();
    out_rdy = 1'b0;
    in_val = 1'b1; in_ch = 3'd1; in_data = 8'd9;
    step();
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1; in_ch = 3'd2; in_data = 8'(i + 1);
      step();
    end
    in_val = 1'b0;
    checks++;
    if (out_val !== 1'b1 || out_sum !== 16'd10) begin
      failures++; $display("FAIL rst_pre got val=%0b sum=%0d exp 1/10", out_val, out_sum);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_val !== 1'b0 || out_sum !== 16'd0 || out_ch !== 3'd0) begin
      failures++; $display("FAIL rst_clear got val=%0b sum=%0d ch=%0d exp 0/0/0", out_val, out_sum, out_ch);
    end
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1; in_ch = 3'd1; in_data = 8'd1;
      step();
    end
    in_val = 1'b0;
    checks++;
    if (out_val !== 1'b1 || out_ch !== 3'd1 || out_sum !== 16'd4) begin
      failures++; $display("FAIL rst_fresh got val=%0b ch=%0d sum=%0d exp 1/1/4", out_val, out_ch, out_sum);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_interleave();
    test_backpressure();
    test_overflow();
    test_clr_and_range();
    test_rst_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
